n101_cfgreg_wr_arbiter: RTL and testbench

- Arbitrates write access from two requesters to one shared WIDTH-bit peripheral configuration register vector (async-reset register vector, d/en/q interface).
- Requester 0 is the bus-side register write; requester 1 is the hardware-side update (e.g. timer reload, status capture).
- Each write is a masked read-modify-write against the live register value.
- Sits between the perips bus decode / hardware logic and the register vector; the register vector itself is external.

---
 rtl/n101_cfgreg_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_n101_cfgreg_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/n101_cfgreg_wr_arbiter.sv
// n101_cfgreg_wr_arbiter
// Two-requester round-robin write arbiter for an external configuration
// register vector. Each accepted write is a masked read-modify-write merged
// against the live reg_q, one write every two cycles (IDLE accept, WRITE).
// Optional build macro: N101_CFGREG_HWLOCK_EN adds hw_lock/err0, which block
// requester 0 writes while the hardware holds the lock.
module n101_cfgreg_wr_arbiter #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [WIDTH-1:0] req0_mask,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [WIDTH-1:0] req1_mask,
    input  logic [WIDTH-1:0] reg_q,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_en,
    output logic             done0,
    output logic             done1,
    output logic             busy,
`ifdef N101_CFGREG_HWLOCK_EN
    input  logic             hw_lock,
    output logic             err0,
`endif
    output logic [CNT_W-1:0] wr_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               rr_q, rr_d;        // 0: req0 wins a tie, 1: req1 wins
    logic               win_q, win_d;      // id of the requester being written
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant0, grant1;
    logic               lock_hit;

`ifdef N101_CFGREG_HWLOCK_EN
    logic               err0_q, err0_d;
    // Only a requester 0 transaction sitting in WRITE can be blocked.
    assign lock_hit = (state_q == WRITE) & ~win_q & hw_lock;
    assign err0     = err0_q;
`else
    assign lock_hit = 1'b0;
`endif

    // A lone requester always wins; on a tie rr_q picks the winner.
    assign grant0 = req0_valid & (~req1_valid | ~rr_q);
    assign grant1 = req1_valid & (~req0_valid |  rr_q);

    assign done0  = done0_q;
    assign done1  = done1_q;
    assign wr_cnt = cnt_q;

    // Next-state, handshake and register-vector write port.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        win_d      = win_q;
        data_d     = data_q;
        mask_d     = mask_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        cnt_d      = cnt_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        reg_en     = 1'b0;
        reg_d      = '0;
        busy       = 1'b0;
`ifdef N101_CFGREG_HWLOCK_EN
        err0_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Readys stay low while reset is held so nothing is accepted.
                req0_ready = grant0 & reset;
                req1_ready = grant1 & reset;
                if (grant0 | grant1) begin
                    win_d   = grant1;
                    data_d  = grant1 ? req1_data : req0_data;
                    mask_d  = grant1 ? req1_mask : req0_mask;
                    rr_d    = ~grant1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy    = 1'b1;
                state_d = IDLE;
                if (lock_hit) begin
`ifdef N101_CFGREG_HWLOCK_EN
                    err0_d = 1'b1;
`endif
                end else begin
                    // Merge against live reg_q so back-to-back writes keep
                    // the bits the previous write just landed.
                    reg_en  = 1'b1;
                    reg_d   = (reg_q & ~mask_q) | (data_q & mask_q);
                    done0_d = ~win_q;
                    done1_d =  win_q;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            win_q   <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            cnt_q   <= '0;
`ifdef N101_CFGREG_HWLOCK_EN
            err0_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            cnt_q   <= cnt_d;
`ifdef N101_CFGREG_HWLOCK_EN
            err0_q  <= err0_d;
`endif
        end
    end

endmodule

// File: tb/tb_n101_cfgreg_wr_arbiter.sv
// Bench for n101_cfgreg_wr_arbiter: directed writes, a scoreboard queue of
// expected completions, and a negedge monitor that checks every write strobe
// and every done/err pulse. A second instance with CNT_W=2 shares the
// stimulus to exercise counter saturation.
module tb_n101_cfgreg_wr_arbiter;

    localparam int W = 20;

    logic          clock, reset;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready, req0_ready2, req1_ready2;
    logic [W-1:0]  req0_data, req0_mask, req1_data, req1_mask;
    logic [W-1:0]  regv, reg_d, reg_d2, ld_val;
    logic          ld;
    logic          reg_en, reg_en2, done0, done1, done0_2, done1_2, busy, busy2;
    logic [7:0]    wr_cnt;
    logic [1:0]    wr_cnt2;
    logic          err0_w;
`ifdef N101_CFGREG_HWLOCK_EN
    logic          hw_lock, err0, err0_2;
    assign err0_w = err0;
`else
    assign err0_w = 1'b0;
`endif

    n101_cfgreg_wr_arbiter #(.WIDTH(W), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_mask(req0_mask),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_mask(req1_mask),
        .reg_q(regv), .reg_d(reg_d), .reg_en(reg_en),
        .done0(done0), .done1(done1), .busy(busy),
`ifdef N101_CFGREG_HWLOCK_EN
        .hw_lock(hw_lock), .err0(err0),
`endif
        .wr_cnt(wr_cnt)
    );

    n101_cfgreg_wr_arbiter #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready2),
        .req0_data(req0_data), .req0_mask(req0_mask),
        .req1_valid(req1_valid), .req1_ready(req1_ready2),
        .req1_data(req1_data), .req1_mask(req1_mask),
        .reg_q(regv), .reg_d(reg_d2), .reg_en(reg_en2),
        .done0(done0_2), .done1(done1_2), .busy(busy2),
`ifdef N101_CFGREG_HWLOCK_EN
        .hw_lock(hw_lock), .err0(err0_2),
`endif
        .wr_cnt(wr_cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External register vector model, with a bench-side preload.
    always_ff @(posedge clock) begin
        if (ld)          regv <= ld_val;
        else if (reg_en) regv <= reg_d;
    end

    typedef struct {
        logic         id;
        logic         lock;
        logic [W-1:0] regd;
        logic [W-1:0] fin;
        logic [7:0]   cnt;
        logic [1:0]   cnt2;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic strict  = 1'b1;
    logic seen_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic id, input logic lock, input logic [W-1:0] regd,
                        input logic [W-1:0] fin, input logic [7:0] cnt, input logic [1:0] cnt2);
        exp_t x;
        x.id = id; x.lock = lock; x.regd = regd; x.fin = fin; x.cnt = cnt; x.cnt2 = cnt2;
        expq.push_back(x);
    endtask

    // Monitor: write strobes are checked against the head entry; a done or
    // err pulse retires it.
    always @(negedge clock) begin
        if (reg_en) begin
            if (expq.size() == 0) begin
                if (strict) check("wr_unexpected", 32'(reg_en), 32'(0));
            end else begin
                check("wr_while_locked", 32'(expq[0].lock), 32'(0));
                check("wr_data", 32'(reg_d), 32'(expq[0].regd));
                check("wr_busy", 32'(busy), 32'(1));
                seen_en = 1'b1;
            end
        end
        if (done0 | done1 | err0_w) begin
            if (expq.size() == 0) begin
                check("done_unexpected", 32'({err0_w, done1, done0}), 32'(0));
            end else begin
                e = expq.pop_front();
                check("done_id", 32'({err0_w, done1, done0}),
                      e.lock ? 32'(4) : (e.id ? 32'(2) : 32'(1)));
                check("done_had_wr", 32'(seen_en), 32'(!e.lock));
                check("done_reg_q", 32'(regv), 32'(e.fin));
                check("done_wr_cnt", 32'(wr_cnt), 32'(e.cnt));
                check("done_wr_cnt_sat", 32'(wr_cnt2), 32'(e.cnt2));
                seen_en = 1'b0;
            end
        end
    end

    task automatic do_req(input logic id, input logic [W-1:0] d, input logic [W-1:0] m);
        int n = 0;
        if (id) begin req1_valid = 1'b1; req1_data = d; req1_mask = m; end
        else    begin req0_valid = 1'b1; req0_data = d; req0_mask = m; end
        @(negedge clock);
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("req_ready", 32'(id ? req1_ready : req0_ready), 32'(1));
        @(posedge clock); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("drain", 32'(expq.size()), 32'(0));
        @(posedge clock); #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        ld = 1'b1; ld_val = v;
        @(posedge clock); #1;
        ld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n;
        reset = 1'b0; ld = 1'b1; ld_val = '0;
        req0_valid = 1'b1; req0_data = 20'h11111; req0_mask = 20'hFFFFF;
        req1_valid = 1'b1; req1_data = 20'h22222; req1_mask = 20'hFFFFF;
`ifdef N101_CFGREG_HWLOCK_EN
        hw_lock = 1'b0;
`endif
        @(posedge clock); #1;
        ld = 1'b0;

        // Reset held with both requesters asking.
        repeat (3) begin
            @(negedge clock);
            check("rst_ready0", 32'(req0_ready), 32'(0));
            check("rst_ready1", 32'(req1_ready), 32'(0));
            check("rst_reg_en", 32'(reg_en), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_done", 32'({done1, done0}), 32'(0));
            check("rst_wr_cnt", 32'(wr_cnt), 32'(0));
        end

        // Fairness from reset: req0, req1, req0, req1, req0.
        push(0, 0, 20'h11111, 20'h11111, 8'd1, 2'd1);
        push(1, 0, 20'h22222, 20'h22222, 8'd2, 2'd2);
        push(0, 0, 20'h11111, 20'h11111, 8'd3, 2'd3);
        push(1, 0, 20'h22222, 20'h22222, 8'd4, 2'd3);
        push(0, 0, 20'h11111, 20'h11111, 8'd5, 2'd3);
        @(posedge clock); #1;
        reset = 1'b1;
        acc = 0; n = 0;
        while (acc < 5 && n < 40) begin
            @(negedge clock);
            n++;
            if (req0_ready | req1_ready) begin
                check("fair_onehot", 32'(req0_ready & req1_ready), 32'(0));
                check("fair_grant", 32'(req1_ready), 32'(acc % 2));
                acc++;
            end
            @(posedge clock); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("fair_accepts", 32'(acc), 32'(5));
        wait_drain();

        // Single masked write with latency checks.
        load(20'h12345);
        push(0, 0, 20'h123DE, 20'h123DE, 8'd6, 2'd3);
        req0_valid = 1'b1; req0_data = 20'hABCDE; req0_mask = 20'h000FF;
        @(negedge clock);
        check("t1_ready", 32'(req0_ready), 32'(1));
        @(posedge clock); #1;
        req0_valid = 1'b0;
        @(negedge clock);
        check("t1_reg_en", 32'(reg_en), 32'(1));
        check("t1_reg_d", 32'(reg_d), 32'(20'h123DE));
        @(negedge clock);
        check("t1_done0", 32'(done0), 32'(1));
        wait_drain();

        // Back-to-back RMW, then mask=0 and mask all-ones.
        load(20'h00000);
        push(1, 0, 20'h0000F, 20'h0000F, 8'd7, 2'd3);
        push(0, 0, 20'hF000F, 20'hF000F, 8'd8, 2'd3);
        do_req(1, 20'hFFFFF, 20'h0000F);
        do_req(0, 20'hFFFFF, 20'hF0000);
        wait_drain();
        push(1, 0, 20'hF000F, 20'hF000F, 8'd9, 2'd3);
        do_req(1, 20'hFFFFF, 20'h00000);
        wait_drain();
        push(0, 0, 20'h5A5A5, 20'h5A5A5, 8'd10, 2'd3);
        do_req(0, 20'h5A5A5, 20'hFFFFF);
        wait_drain();

        // Reset asserted in the WRITE cycle: write lands, no done, count cleared.
        strict = 1'b0;
        req0_valid = 1'b1; req0_data = 20'h33333; req0_mask = 20'hFFFFF;
        @(negedge clock);
        check("rw_ready", 32'(req0_ready), 32'(1));
        @(posedge clock); #1;
        req0_valid = 1'b0; reset = 1'b0;
        @(negedge clock);
        check("rw_reg_en", 32'(reg_en), 32'(1));
        check("rw_reg_d", 32'(reg_d), 32'(20'h33333));
        @(negedge clock);
        check("rw_done", 32'({done1, done0}), 32'(0));
        check("rw_busy", 32'(busy), 32'(0));
        check("rw_wr_cnt", 32'(wr_cnt), 32'(0));
        check("rw_reg_q", 32'(regv), 32'(20'h33333));
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rw_done_after", 32'({done1, done0}), 32'(0));
        check("rw_idle", 32'(busy), 32'(0));
        strict = 1'b1;
        @(posedge clock); #1;

`ifdef N101_CFGREG_HWLOCK_EN
        // Locked req0 write is dropped with err0; req1 still lands.
        hw_lock = 1'b1;
        push(0, 1, 20'h00000, 20'h33333, 8'd0, 2'd0);
        do_req(0, 20'h0F0F0, 20'hFFFFF);
        wait_drain();
        push(1, 0, 20'h33344, 20'h33344, 8'd1, 2'd1);
        do_req(1, 20'h44444, 20'h000FF);
        wait_drain();
        hw_lock = 1'b0;
`else
        push(0, 0, 20'h0F0F0, 20'h0F0F0, 8'd1, 2'd1);
        do_req(0, 20'h0F0F0, 20'hFFFFF);
        wait_drain();
        push(1, 0, 20'h0F044, 20'h0F044, 8'd2, 2'd2);
        do_req(1, 20'h44444, 20'h000FF);
        wait_drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
